ucsbece154a_run_checker: RTL and testbench

//  Synthesizable run-and-check controller for processor bring-up. Pulses DUT reset, lets the
//  DUT run for a bounded cycle budget (or until it halts), then snapshots NUM_CHK watched

---
 rtl/ucsbece154a_runchk_pkg.sv | 15 +
 rtl/ucsbece154a_runchk_cmp.sv | 13 +
 rtl/ucsbece154a_run_checker.sv | 133 +++++++++++++
 tb/tb_ucsbece154a_run_checker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154a_runchk_pkg.sv
// Shared types for the run-and-check controller: FSM state encoding.
package ucsbece154a_runchk_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        RST   = 3'd1,
        RUN   = 3'd2,
        SNAP  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/ucsbece154a_runchk_cmp.sv
// One-channel masked compare: flags a mismatch only when the channel is enabled.
module ucsbece154a_runchk_cmp #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] watch,
    input  logic [WIDTH-1:0] expected,
    input  logic             check_en,
    output logic             mismatch
);

    assign mismatch = check_en && (watch != expected);

endmodule

// File: rtl/ucsbece154a_run_checker.sv
// Run-and-check controller: resets the DUT, runs it for a bounded budget, snapshots and checks.
// Define UCSBECE154A_RUNCHK_HALT_EN to let halt_i end a run before the cycle budget.
module ucsbece154a_run_checker
    import ucsbece154a_runchk_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NUM_CHK     = 9,
    parameter int CNT_W       = 16,
    parameter int CYCLE_LIMIT = 100,
    parameter int RST_CYCLES  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic                     halt_i,
    input  logic [NUM_CHK*WIDTH-1:0] watch_i,
    input  logic [NUM_CHK*WIDTH-1:0] expect_i,
    input  logic [NUM_CHK-1:0]       chk_mask_i,
    output logic                     dut_reset_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     pass_o,
    output logic                     timeout_o,
    output logic [NUM_CHK-1:0]       fail_mask_o,
    output logic [CNT_W-1:0]         cycle_o
);

    localparam int IDX_W  = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1;
    localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  LIMIT    = CNT_W'(CYCLE_LIMIT);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CHK - 1);
    localparam logic [RCNT_W-1:0] LAST_RST = RCNT_W'(RST_CYCLES - 1);

    state_t                   state;
    logic [RCNT_W-1:0]        rst_cnt;
    logic [IDX_W-1:0]         idx;
    logic [NUM_CHK*WIDTH-1:0] snap;
    logic                     mismatch;
    logic                     halt_hit;

`ifdef UCSBECE154A_RUNCHK_HALT_EN
    assign halt_hit = halt_i;
`else
    logic unused_halt;
    assign unused_halt = halt_i;
    assign halt_hit    = 1'b0;
`endif

    // Checks run against the snapshot, so DUT activity after SNAP cannot alter results.
    ucsbece154a_runchk_cmp #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .watch   (snap[idx*WIDTH +: WIDTH]),
        .expected(expect_i[idx*WIDTH +: WIDTH]),
        .check_en(chk_mask_i[idx]),
        .mismatch(mismatch)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            dut_reset_o <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            timeout_o   <= 1'b0;
            fail_mask_o <= '0;
            cycle_o     <= '0;
            rst_cnt     <= '0;
            idx         <= '0;
            snap        <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state       <= RST;
                        dut_reset_o <= 1'b1;
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                        pass_o      <= 1'b0;
                        timeout_o   <= 1'b0;
                        fail_mask_o <= '0;
                        cycle_o     <= '0;
                        rst_cnt     <= '0;
                    end
                end
                RST: begin
                    if (rst_cnt == LAST_RST) begin
                        state       <= RUN;
                        dut_reset_o <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                // The cycle that observes halt (or the budget) still counts as a RUN cycle.
                RUN: begin
                    if (cycle_o != LIMIT) begin
                        cycle_o <= cycle_o + 1'b1;
                    end
                    if (halt_hit) begin
                        state     <= SNAP;
                        timeout_o <= 1'b0;
                    end else if (cycle_o >= LIMIT - 1'b1) begin
                        state     <= SNAP;
                        timeout_o <= 1'b1;
                    end
                end
                SNAP: begin
                    snap  <= watch_i;
                    idx   <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_mask_o[idx] <= 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        pass_o <= (fail_mask_o == '0) && !mismatch;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ucsbece154a_run_checker.sv
// Scoreboard bench for ucsbece154a_run_checker; honours UCSBECE154A_RUNCHK_HALT_EN if defined.
module tb_ucsbece154a_run_checker;

    localparam int WIDTH       = 32;
    localparam int NUM_CHK     = 4;
    localparam int CNT_W       = 16;
    localparam int CYCLE_LIMIT = 10;
    localparam int RST_CYCLES  = 2;

`ifdef UCSBECE154A_RUNCHK_HALT_EN
    localparam bit HALT_ON = 1'b1;
`else
    localparam bit HALT_ON = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [3:0] failMask;
        logic       pass;
        logic       timeout;
        int         cycles;
        int         busyCycles;
    } exp_t;

    logic                     clk;
    logic                     reset;
    logic                     start_i;
    logic                     halt_i;
    logic [NUM_CHK*WIDTH-1:0] watch_i;
    logic [NUM_CHK*WIDTH-1:0] expect_i;
    logic [NUM_CHK-1:0]       chk_mask_i;
    logic                     dut_reset_o;
    logic                     busy_o;
    logic                     done_o;
    logic                     pass_o;
    logic                     timeout_o;
    logic [NUM_CHK-1:0]       fail_mask_o;
    logic [CNT_W-1:0]         cycle_o;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    ucsbece154a_run_checker #(
        .WIDTH      (WIDTH),
        .NUM_CHK    (NUM_CHK),
        .CNT_W      (CNT_W),
        .CYCLE_LIMIT(CYCLE_LIMIT),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .halt_i     (halt_i),
        .watch_i    (watch_i),
        .expect_i   (expect_i),
        .chk_mask_i (chk_mask_i),
        .dut_reset_o(dut_reset_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .pass_o     (pass_o),
        .timeout_o  (timeout_o),
        .fail_mask_o(fail_mask_o),
        .cycle_o    (cycle_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, required);
        end
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] c0, input logic [31:0] c1,
                                           input logic [31:0] c2, input logic [31:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    // Monitor: measures each run's busy/DUT-reset lengths and scores the result on done.
    initial begin : monitor
        bit   busyPrev;
        bit   donePrev;
        int   busyCnt;
        int   rstCnt;
        exp_t ex;
        busyPrev = 1'b0;
        donePrev = 1'b0;
        busyCnt  = 0;
        rstCnt   = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busyCnt = 0;
                rstCnt  = 0;
            end else if (busy_o) begin
                if (!busyPrev) begin
                    busyCnt = 0;
                    rstCnt  = 0;
                end
                busyCnt++;
                if (dut_reset_o) rstCnt++;
            end
            if (done_o && !donePrev) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    ex = expQ.pop_front();
                    checkOutput({ex.tag, "_fail_mask"}, 32'(fail_mask_o), 32'(ex.failMask));
                    checkOutput({ex.tag, "_pass"}, 32'(pass_o), 32'(ex.pass));
                    checkOutput({ex.tag, "_timeout"}, 32'(timeout_o), 32'(ex.timeout));
                    checkOutput({ex.tag, "_cycle"}, 32'(cycle_o), ex.cycles);
                    checkOutput({ex.tag, "_busy_cycles"}, busyCnt, ex.busyCycles);
                    checkOutput({ex.tag, "_dut_reset_cycles"}, rstCnt, RST_CYCLES);
                end
            end
            busyPrev = busy_o;
            donePrev = done_o;
        end
    end

    // One full run: queue the expected result, pulse start, drive halt/start/watch events by cycle.
    task automatic applyStimulus(input string tag, input logic [127:0] w, input logic [127:0] e,
                                 input logic [3:0] m, input int haltAt, input bit zeroAfterSnap,
                                 input bit startInRun, input logic [3:0] expFail, input bit expPass,
                                 input bit expTimeout, input int expCycles, input int expBusy);
        exp_t ex;
        int   c;
        ex.tag        = tag;
        ex.failMask   = expFail;
        ex.pass       = expPass;
        ex.timeout    = expTimeout;
        ex.cycles     = expCycles;
        ex.busyCycles = expBusy;
        expQ.push_back(ex);
        watch_i    = w;
        expect_i   = e;
        chk_mask_i = m;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        checkOutput({tag, "_start_done_clr"}, 32'(done_o), 32'd0);
        checkOutput({tag, "_start_busy"}, 32'(busy_o), 32'd1);
        checkOutput({tag, "_start_mask_clr"}, 32'(fail_mask_o), 32'd0);
        checkOutput({tag, "_start_pass_clr"}, 32'(pass_o), 32'd0);
        checkOutput({tag, "_start_cycle_clr"}, 32'(cycle_o), 32'd0);
        c = 0;
        while (!done_o && c < 60) begin
            @(negedge clk);
            c++;
            halt_i  = (haltAt > 0) && (c == haltAt + 1);
            start_i = startInRun && (c == 4);
            if (zeroAfterSnap && c == 13) watch_i = '0;
        end
        halt_i  = 1'b0;
        start_i = 1'b0;
        if (!done_o) checkOutput({tag, "_done_seen"}, 32'd0, 32'd1);
    endtask

    initial begin
        logic [127:0] base;
        logic [127:0] misW;
        logic [127:0] misE;
        reset      = 1'b0;
        start_i    = 1'b0;
        halt_i     = 1'b0;
        watch_i    = '0;
        expect_i   = '0;
        chk_mask_i = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_dut_reset", 32'(dut_reset_o), 32'd1);
        checkOutput("reset_busy", 32'(busy_o), 32'd0);
        checkOutput("reset_done", 32'(done_o), 32'd0);
        checkOutput("reset_pass", 32'(pass_o), 32'd0);
        checkOutput("reset_timeout", 32'(timeout_o), 32'd0);
        checkOutput("reset_fail_mask", 32'(fail_mask_o), 32'd0);
        checkOutput("reset_cycle", 32'(cycle_o), 32'd0);
        reset = 1'b1;

        base = pack4(32'h11, 32'h22, 32'h33, 32'h44);
        misW = pack4(32'h11, 32'h22, 32'd7, 32'h44);
        misE = pack4(32'h11, 32'h22, 32'd9, 32'h44);

        applyStimulus("all_match", base, base, 4'b1111, 0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 10, 17);
        repeat (3) @(negedge clk);
        checkOutput("hold_done", 32'(done_o), 32'd1);
        checkOutput("hold_pass", 32'(pass_o), 32'd1);
        checkOutput("hold_dut_running", 32'(dut_reset_o), 32'd0);

        applyStimulus("mismatch_ch2", misW, misE, 4'b1111, 0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 10, 17);
        applyStimulus("masked_ch2", misW, misE, 4'b1011, 0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 10, 17);

        if (HALT_ON) begin
            applyStimulus("halt_at_4", base, base, 4'b1111, 4, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4, 11);
            applyStimulus("halt_at_10", base, base, 4'b1111, 10, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 10, 17);
        end else begin
            applyStimulus("halt_at_4", base, base, 4'b1111, 4, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 10, 17);
            applyStimulus("halt_at_10", base, base, 4'b1111, 10, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 10, 17);
        end

        applyStimulus("snap_hold", pack4(32'd0, 32'hBEEF000, 32'd0, 32'd0),
                      pack4(32'd0, 32'hBEEF000, 32'd0, 32'd0), 4'b1111, 0, 1'b1, 1'b0,
                      4'b0000, 1'b1, 1'b1, 10, 17);
        applyStimulus("start_in_run", base, base, 4'b1111, 0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 10, 17);

        // Abort a run mid-CHECK once channel 0's mismatch is already recorded.
        watch_i    = pack4(32'hA, 32'h22, 32'h33, 32'h44);
        expect_i   = pack4(32'hB, 32'h22, 32'h33, 32'h44);
        chk_mask_i = 4'b1111;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("abort_pre_fail_mask", 32'(fail_mask_o), 32'd1);
        checkOutput("abort_pre_cycle", 32'(cycle_o), 32'd10);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_dut_reset", 32'(dut_reset_o), 32'd1);
        checkOutput("abort_busy", 32'(busy_o), 32'd0);
        checkOutput("abort_done", 32'(done_o), 32'd0);
        checkOutput("abort_timeout", 32'(timeout_o), 32'd0);
        checkOutput("abort_fail_mask", 32'(fail_mask_o), 32'd0);
        checkOutput("abort_cycle", 32'(cycle_o), 32'd0);
        reset = 1'b1;

        applyStimulus("after_reset", base, base, 4'b1111, 0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 10, 17);
        applyStimulus("mismatch_ch0_ch3", pack4(32'd1, 32'd2, 32'd3, 32'd4),
                      pack4(32'd5, 32'd2, 32'd3, 32'd6), 4'b1111, 0, 1'b0, 1'b0,
                      4'b1001, 1'b0, 1'b1, 10, 17);

        repeat (2) @(negedge clk);
        if (expQ.size() != 0) checkOutput("queue_drained", expQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
